// File: rtl/moore_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : moore_seq_gen                                                  |
// | Purpose : Parametrised Moore sequencer with programmable dwell per state |
// |           and up / down / ping-pong / one-shot run modes.                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module moore_seq_gen #(
  parameter int NUM_STATES = 4,
  parameter int STATE_W    = $clog2(NUM_STATES),
  parameter int DWELL_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  load,
  input  logic [STATE_W-1:0]    load_state,
  output logic [STATE_W-1:0]    out_state,
  output logic [NUM_STATES-1:0] out_onehot,
  output logic                  wrap,
  output logic                  dir,
  output logic                  done
);

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic [STATE_W-1:0] FIRST_STATE = '0;
  localparam logic [STATE_W-1:0] LAST_STATE  = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] ONE_STATE   = STATE_W'(1);
  localparam logic [STATE_W:0]   NUM_WIDE    = (STATE_W+1)'(NUM_STATES);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [STATE_W-1:0] w_adv_state;
  logic               w_adv_dir;
  logic               w_adv_wrap;
  logic [STATE_W-1:0] w_load_clamped;
  logic               w_in_range;
  logic               w_hold_last;
  mode_e              w_mode;

  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_mode         = mode_e'(mode);
  assign w_in_range     = ({1'b0, r_state} < NUM_WIDE);
  assign w_load_clamped = ({1'b0, load_state} >= NUM_WIDE) ? LAST_STATE : load_state;
  assign w_hold_last    = (w_mode == MODE_ONESHOT) && (r_state == LAST_STATE);

  always_comb begin
    w_adv_state = r_state;
    w_adv_dir   = r_dir;
    w_adv_wrap  = 1'b0;
    if (!w_in_range) begin
      w_adv_state = FIRST_STATE;
    end else begin
      case (w_mode)
        MODE_UP: begin
          if (r_state == LAST_STATE) begin
            w_adv_state = FIRST_STATE;
            w_adv_wrap  = 1'b1;
          end else begin
            w_adv_state = r_state + ONE_STATE;
          end
        end
        MODE_DOWN: begin
          if (r_state == FIRST_STATE) begin
            w_adv_state = LAST_STATE;
            w_adv_wrap  = 1'b1;
          end else begin
            w_adv_state = r_state - ONE_STATE;
          end
        end
        MODE_PINGPONG: begin
          if (!r_dir) begin
            if (r_state == LAST_STATE) begin
              w_adv_state = LAST_STATE - ONE_STATE;
              w_adv_dir   = 1'b1;
              w_adv_wrap  = 1'b1;
            end else begin
              w_adv_state = r_state + ONE_STATE;
            end
          end else begin
            if (r_state == FIRST_STATE) begin
              w_adv_state = ONE_STATE;
              w_adv_dir   = 1'b0;
              w_adv_wrap  = 1'b1;
            end else begin
              w_adv_state = r_state - ONE_STATE;
            end
          end
        end
        MODE_ONESHOT: begin
          // The terminal state is handled by w_hold_last, so here we only climb.
          w_adv_state = r_state + ONE_STATE;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      w_state_nxt = w_load_clamped;
      w_cnt_nxt   = '0;
    end else if (en && !w_hold_last) begin
      // >= lets a dwell lowered mid-hold take effect on the very next clock.
      if (r_cnt >= dwell) begin
        w_state_nxt = w_adv_state;
        w_dir_nxt   = w_adv_dir;
        w_wrap_nxt  = w_adv_wrap;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + DWELL_W'(1);
      end
    end
    w_done_nxt = (w_mode == MODE_ONESHOT) && (w_state_nxt == LAST_STATE);
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= FIRST_STATE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_onehot
    assign out_onehot[gi] = (r_state == STATE_W'(gi));
  end

  assign out_state = r_state;
  assign wrap      = r_wrap;
  assign dir       = r_dir;
  assign done      = r_done;

endmodule
`default_nettype wire
